// File: rtl/shift_unit_seq.sv
//==============================================================================
// Module   : shift_unit_seq
// Purpose  : Multi-cycle shift/rotate unit (LSL/LSR/ASR/ROL), one bit per clock,
//            with registered result, carry-out and sticky signed-overflow flag.
//            Define SHIFT_UNIT_BARREL_EN for a single-cycle barrel build.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module shift_unit_seq #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] x,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             ovf
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0]       C_LSL       = 2'b00;
    localparam logic [1:0]       C_LSR       = 2'b01;
    localparam logic [1:0]       C_ASR       = 2'b10;
    localparam logic [1:0]       C_ROL       = 2'b11;
    localparam logic [AMT_W-1:0] C_WIDTH_AMT = AMT_W'(WIDTH);

    // One 1-bit step. Returns {ovf_acc, cout, value}.
    function automatic logic [WIDTH+1:0] step_one(
        input logic [WIDTH-1:0] v,
        input logic [1:0]       m,
        input logic             ov
    );
        logic [WIDTH+1:0] res;
        case (m)
            C_LSL:   res = {ov | (v[WIDTH-1] ^ v[WIDTH-2]), v[WIDTH-1], v[WIDTH-2:0], 1'b0};
            C_LSR:   res = {ov, v[0], 1'b0, v[WIDTH-1:1]};
            C_ASR:   res = {ov, v[0], v[WIDTH-1], v[WIDTH-1:1]};
            default: res = {ov, v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
        endcase
        return res;
    endfunction

    state_t           r_state;
    logic [AMT_W-1:0] w_cnt_load;

    assign w_cnt_load = (amount > C_WIDTH_AMT) ? C_WIDTH_AMT : amount;

`ifdef SHIFT_UNIT_BARREL_EN
    // Unrolled chain of single steps: bit-identical to the iterative build.
    logic [WIDTH+1:0] w_bar;

    always_comb begin
        w_bar = {2'b00, x};
        for (int i = 0; i < WIDTH; i++) begin
            if (i < int'(w_cnt_load)) begin
                w_bar = step_one(w_bar[WIDTH-1:0], mode, w_bar[WIDTH+1]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            ready   <= 1'b1;
            done    <= 1'b0;
            f       <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_DONE;
                        ready   <= 1'b0;
                        done    <= 1'b1;
                        f       <= w_bar[WIDTH-1:0];
                        cout    <= w_bar[WIDTH];
                        ovf     <= w_bar[WIDTH+1];
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    ready   <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    ready   <= 1'b1;
                end
            endcase
        end
    end
`else
    logic [WIDTH-1:0] r_work;
    logic [1:0]       r_mode;
    logic [AMT_W-1:0] r_cnt;
    logic             r_ovf_int;
    logic [WIDTH+1:0] w_step;

    assign w_step = step_one(r_work, r_mode, r_ovf_int);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            ready     <= 1'b1;
            done      <= 1'b0;
            f         <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            r_work    <= '0;
            r_mode    <= C_LSL;
            r_cnt     <= '0;
            r_ovf_int <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        ready     <= 1'b0;
                        r_work    <= x;
                        r_mode    <= mode;
                        r_cnt     <= w_cnt_load;
                        r_ovf_int <= 1'b0;
                        if (w_cnt_load == '0) begin
                            // Zero shift: pass operand straight through.
                            r_state <= S_DONE;
                            done    <= 1'b1;
                            f       <= x;
                            cout    <= 1'b0;
                            ovf     <= 1'b0;
                        end else begin
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    r_work    <= w_step[WIDTH-1:0];
                    r_ovf_int <= w_step[WIDTH+1];
                    r_cnt     <= r_cnt - 1'b1;
                    if (r_cnt == AMT_W'(1)) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                        f       <= w_step[WIDTH-1:0];
                        cout    <= w_step[WIDTH];
                        ovf     <= w_step[WIDTH+1];
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    ready   <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    ready   <= 1'b1;
                end
            endcase
        end
    end
`endif

endmodule

`default_nettype wire
